// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one branch comparator among N_REQ requesters.
// One transaction in flight: IDLE grants, EVAL computes, RESP holds the result.
package cmp_pkg;
  localparam int CMPOP_WIDTH = 3;
  localparam logic [CMPOP_WIDTH-1:0] OP_BEQ  = 3'b000;
  localparam logic [CMPOP_WIDTH-1:0] OP_BNE  = 3'b001;
  localparam logic [CMPOP_WIDTH-1:0] OP_BLT  = 3'b100;
  localparam logic [CMPOP_WIDTH-1:0] OP_BGE  = 3'b101;
  localparam logic [CMPOP_WIDTH-1:0] OP_BLTU = 3'b110;
  localparam logic [CMPOP_WIDTH-1:0] OP_BGEU = 3'b111;
endpackage

module cmp_unit
  import cmp_pkg::*;
(
  input  logic [CMPOP_WIDTH-1:0] op,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  output logic                   res
);
  always_comb begin
    res = 1'b0;
    case (op)
      OP_BEQ:  res = (a == b);
      OP_BNE:  res = (a != b);
      OP_BLT:  res = ($signed(a) < $signed(b));
      OP_BGE:  res = ($signed(a) >= $signed(b));
      OP_BLTU: res = (a < b);
      OP_BGEU: res = (a >= b);
      default: res = 1'b0;
    endcase
  end
endmodule

module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*CMPOP_WIDTH-1:0] req_op,
  input  logic [N_REQ*32-1:0]          req_a,
  input  logic [N_REQ*32-1:0]          req_b,
  output logic [N_REQ-1:0]             resp_valid,
  input  logic [N_REQ-1:0]             resp_ready,
  output logic                         resp_out,
  output logic                         busy
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t               state;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       owner;
  logic [CMPOP_WIDTH-1:0] op_q;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  logic                 cmp_res;
  logic                 gnt_vld;
  logic [IDW-1:0]       gnt;
  logic [IDW-1:0]       gnt_nxt;
  int                   idx;

  cmp_unit u_cmp (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (cmp_res)
  );

  // search starts at rr_ptr and wraps at N_REQ, not at 2**IDW
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = IDW'(idx);
      end
    end
  end

  assign gnt_nxt = (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_vld)
      req_ready[gnt] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP)
      resp_valid[owner] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      resp_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            op_q   <= req_op[int'(gnt)*CMPOP_WIDTH +: CMPOP_WIDTH];
            a_q    <= req_a[int'(gnt)*32 +: 32];
            b_q    <= req_b[int'(gnt)*32 +: 32];
            owner  <= gnt;
            rr_ptr <= gnt_nxt;
            state  <= EVAL;
          end
        end
        EVAL: begin
          resp_out <= cmp_res;
          state    <= RESP;
        end
        RESP: begin
          if (resp_ready[owner])
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
